// File: rtl/snn_cdc_pkg.sv
// Shared types for the SNN-to-AXI pulse arbiter slice.
// Arbiter FSM encoding and the requester-ID width helper.
package snn_cdc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cdc_pulse_arbiter_if.sv
// Requester/channel bundle of the pulse arbiter.
// master drives requests and channel status; slave is the arbiter.
interface cdc_pulse_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);

  logic [N_REQ-1:0] req_pulse;
  logic             ch_busy;
  logic             ch_done;
  logic [N_REQ-1:0] ovf_clr;
  logic             ch_pulse;
  logic [ID_W-1:0]  ch_sel;
  logic [N_REQ-1:0] req_done;
  logic [N_REQ-1:0] pending;
  logic [N_REQ-1:0] ovf;
  logic             busy;
  logic             timeout_err;

  modport master (
    output req_pulse, ch_busy, ch_done, ovf_clr,
    input  ch_pulse, ch_sel, req_done,
    input  pending, ovf, busy, timeout_err
  );

  modport slave (
    input  req_pulse, ch_busy, ch_done, ovf_clr,
    output ch_pulse, ch_sel, req_done,
    output pending, ovf, busy, timeout_err
  );

endinterface

// File: rtl/cdc_pulse_arbiter_rr_pick.sv
// Round-robin pick: first set bit of req above last, else lowest set bit.
// Ports: req (candidates), last (previous winner), any, id (winner).
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic             any,
  output logic [ID_W-1:0]  id
);

  logic [N_REQ-1:0] mask;
  logic [N_REQ-1:0] hi;
  logic             use_hi;

  always_comb begin
    mask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      mask[i] = (i > int'(last));
    end
    hi     = req & mask;
    use_hi = |hi;
    any    = |req;
    id     = '0;
    // Scan downward so the lowest qualifying index wins.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (use_hi ? hi[i] : req[i]) begin
        id = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/cdc_pulse_arbiter.sv
// Shares one acknowledged pulse-sync channel among N_REQ event sources.
// Ports: clk, rst (sync, active-high), bus (slave side of the bundle).
module cdc_pulse_arbiter
  import snn_cdc_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 1024,
  parameter int ID_W    = id_width(N_REQ)
) (
  input logic               clk,
  input logic               rst,
  cdc_pulse_arbiter_if.slave bus
);

  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q [N_REQ];
  logic [N_REQ-1:0] ovf_q;
  logic [N_REQ-1:0] ovf_set;
  logic [N_REQ-1:0] pend;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] done_vec;
  logic [ID_W-1:0]  sel_q;
  logic [ID_W-1:0]  last_q;
  logic [ID_W-1:0]  pick_id;
  logic             pick_any;
  logic             load;
  logic [WD_W-1:0]  wd_q;
  logic             tmo_q;

  always_comb begin
    pend     = '0;
    grant    = '0;
    done_vec = '0;
    ovf_set  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pend[i]     = (cnt_q[i] != '0);
      grant[i]    = (state_q == ST_ISSUE) &&
                    (sel_q == ID_W'(i));
      done_vec[i] = (state_q == ST_WAIT) &&
                    bus.ch_done &&
                    (sel_q == ID_W'(i));
      ovf_set[i]  = bus.req_pulse[i] && !grant[i] &&
                    (cnt_q[i] == CNT_MAX);
    end
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req  (pend),
    .last (last_q),
    .any  (pick_any),
    .id   (pick_id)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any && !bus.ch_busy) begin
          state_d = ST_ISSUE;
          load    = 1'b1;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.ch_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        cnt_q[i] <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (bus.req_pulse[i] && !grant[i]) begin
          if (cnt_q[i] != CNT_MAX) begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end else if (!bus.req_pulse[i] && grant[i]) begin
          cnt_q[i] <= cnt_q[i] - 1'b1;
        end
      end
      // A fresh overflow beats a same-cycle clear.
      ovf_q <= ovf_set | (ovf_q & ~bus.ovf_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      last_q  <= ID_W'(N_REQ - 1);
      wd_q    <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        sel_q  <= pick_id;
        last_q <= pick_id;
      end
      if (state_q == ST_ISSUE) begin
        wd_q <= '0;
      end else if (state_q == ST_WAIT &&
                   wd_q != WD_MAX) begin
        wd_q <= wd_q + 1'b1;
      end
      // Only flag; dropping the wait would desync the channel.
      if (TIMEOUT != 0 && state_q == ST_WAIT &&
          wd_q == WD_LAST) begin
        tmo_q <= 1'b1;
      end
    end
  end

  assign bus.ch_pulse    = (state_q == ST_ISSUE);
  assign bus.ch_sel      = sel_q;
  assign bus.req_done    = done_vec;
  assign bus.pending     = pend;
  assign bus.ovf         = ovf_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.timeout_err = tmo_q;

endmodule

// File: doc/cdc_pulse_arbiter.md
# cdc_pulse_arbiter

Source-domain arbiter that shares one acknowledged pulse-synchronizer channel (`sync_pulse_ack`) among `N_REQ` event sources, e.g. layer-done, spike-buffer-overflow and DMA-complete notices crossing from the SNN core clock to the AXI clock. Per-requester saturating counters queue pulses so none are lost while the channel is busy. A round-robin FSM issues one channel pulse at a time and holds the requester ID stable until the channel reports completion. A watchdog flags a hung handshake.

## Interface
- `N_REQ`, 4: number of requesters, 2..16
- `CNT_W`, 4: pending-counter width per requester
- `TIMEOUT`, 1024: cycles in WAIT_DONE before `timeout_err` sets; 0 disables the watchdog
- `ID_W`, $clog2(N_REQ): width of `ch_sel`
- `clk` in 1: single clock; the channel's `src_clk`
- `rst` in 1: synchronous, active-high reset
- `req_pulse` in N_REQ: one-cycle event pulses, one bit per requester
- `ch_busy` in 1: from channel `src_busy`
- `ch_done` in 1: from channel `src_done`, one-cycle pulse
- `ovf_clr` in N_REQ: write-1-clear for `ovf`
- `ch_pulse` out 1: to channel `src_pulse`, one-cycle pulse
- `ch_sel` out ID_W: requester ID of the in-flight transfer; quasi-static bus sampled by the destination on `dst_pulse`
- `req_done` out N_REQ: one-cycle pulse on bit `ch_sel` when a transfer completes
- `pending` out N_REQ: bit i = counter i nonzero
- `ovf` out N_REQ: sticky; set when a pulse arrives while counter i is saturated
- `busy` out 1: FSM not in IDLE
- `timeout_err` out 1: sticky; cleared only by `rst`

## Operation
- Counters `cnt[i]`, CNT_W bits, reset 0. Each cycle:
  - +1 if `req_pulse[i]`.
  - −1 if i is granted, where "granted" means the ISSUE cycle for `ch_sel==i`.
  - If both happen in the same cycle, the count is unchanged.
  - If `cnt[i]` equals all-ones and a pulse arrives without a grant, the count holds and `ovf[i]` sets.
  - If `ovf_clr[i]` and a new overflow occur in the same cycle, set wins.
- FSM states: IDLE, ISSUE, WAIT_DONE.
  - IDLE→ISSUE: any `cnt` is nonzero and `ch_busy` is 0. The winner is the first nonzero index scanning from `last+1` mod N_REQ. `ch_sel` and `last` load with the winner.
  - ISSUE→WAIT_DONE: always. `ch_pulse` is 1 and the winner's counter decrements.
  - WAIT_DONE→IDLE: on `ch_done`. `req_done[ch_sel]` pulses in the same cycle.
- `ch_sel` changes only on the IDLE→ISSUE transition. Otherwise it holds.
- Watchdog counter clears on entry to WAIT_DONE and increments each WAIT_DONE cycle. At `TIMEOUT` it sets `timeout_err` and saturates. The FSM keeps waiting: aborting would desynchronize the handshake.
- `ch_done` outside WAIT_DONE is ignored.
- Reset values: all counters and outputs 0; `last` = N_REQ−1, so the first grant scan starts at index 0; state IDLE.
- Reset mid-transfer discards all queued pulses. The channel must be reset by the same `rst` (inverted to `src_rst_n`) and by its destination reset.

## Timing
- Best case: `req_pulse` at cycle t gives `pending` = 1 at t+1. IDLE grants at t+1, so ISSUE and `ch_pulse` are at t+2. A `req_pulse` at t is visible to grant logic at t+1.
- After `ch_done` at cycle d, the earliest next `ch_pulse` is d+2 (IDLE at d+1, ISSUE at d+2), provided `ch_busy` has fallen.
- Minimum spacing between `ch_pulse` assertions: 3 cycles plus channel round trip.
- Throughput fairness: with all requesters continuously pending, grant order is 0,1,…,N_REQ−1,0,…

## Structure
- Shared package `snn_cdc_pkg`: FSM state encoding, `ID_W` helper function.
- Sub-module `rr_pick`: combinational round-robin priority encoder (mask from `last`, two-pass find-first). Everything else lives in the top module.
- Top-level integration instantiates `cdc_pulse_arbiter` plus one `sync_pulse_ack`.

## Test plan
- **Single request.** Stimulus: reset, then `req_pulse`=4'b0100 at cycle 10, with a channel model that returns `ch_done` 8 cycles after `ch_pulse`. Required: `ch_pulse` at cycle 12, `ch_sel`=2, `req_done`=4'b0100 at cycle 20, `busy` back to 0 at cycle 21.
- **Simultaneous requests.** Stimulus: `req_pulse`=4'b1111 in one cycle. Required: grants in order 0,1,2,3; each `cnt` returns to 0; exactly 4 `ch_pulse`.
- **Saturation.** Stimulus (CNT_W=4): 17 pulses on requester 1 while `ch_busy`=1. Required: `cnt[1]`=15 and `ovf[1]`=1. Then `ovf_clr[1]` clears it, and after `ch_busy` drops exactly 15 transfers occur.
- **Increment with grant.** Stimulus: `req_pulse[0]` in the same ISSUE cycle that grants 0, with `cnt[0]`=1 beforehand. Required: `cnt[0]` stays 1 and a second transfer follows.
- **Watchdog.** Stimulus (TIMEOUT=16): channel never returns `ch_done`. Required: `timeout_err`=1 after 16 WAIT_DONE cycles; FSM stays in WAIT_DONE; a late `ch_done` completes the transfer normally.
- **Reset mid-transfer.** Stimulus: `rst` during WAIT_DONE with 3 queued pulses. Required: all outputs 0 the next cycle, `pending`=0, and the first post-reset grant goes to the lowest pending index.
